// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between the UART receiver and transmitter in the echo path.
// Bytes arrive on one-cycle wr_en pulses and are replayed in order as one-cycle
// tx_en pulses whenever the transmitter reports ready. After each tx_en, tx_rdy
// is ignored for HOLDOFF cycles while the transmitter drops its rdy line.
//
// Handshake: wr_en is a fire-and-forget strobe (no back-pressure). A write into
// a full FIFO is dropped and sets the sticky overflow flag, unless a pop happens
// on the same edge. tx_en is a single-cycle start pulse that is issued only when
// tx_rdy=1 is sampled in IDLE and a byte is stored. tx_data is valid from tx_en
// until the next pop.
module uart_tx_fifo #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int HOLDOFF = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          tx_rdy,
  output logic          tx_en,
  output logic [7:0]    tx_data,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic [1:0]    dbg_state
);

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    state_q, state_d;
  logic          tx_en_q, tx_en_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          overflow_q, overflow_d;
  logic          pop;
  logic          wr_ok;

  // Pop and write-accept decisions; a full FIFO still accepts a write on a pop edge.
  always_comb begin
    pop   = (state_q == ST_IDLE) && (count_q != '0) && tx_rdy;
    wr_ok = wr_en && ((count_q != DEPTH_C) || pop);
  end

  // Next-state logic for pointers, occupancy, overflow and the transmit FSM.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    hold_d     = hold_q;
    state_d    = state_q;
    tx_en_d    = 1'b0;
    tx_data_d  = tx_data_q;
    overflow_d = overflow_q | (wr_en && !wr_ok);

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    case ({wr_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          tx_en_d   = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
          rd_ptr_d  = rd_ptr_q + 1'b1;
          hold_d    = HOLD_LOAD;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (hold_q == '0) begin
          state_d = ST_WAIT;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      ST_WAIT: begin
        if (tx_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and output registers, cleared asynchronously so outputs drop at once on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hold_q     <= '0;
      state_q    <= ST_IDLE;
      tx_en_q    <= 1'b0;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      hold_q     <= hold_d;
      state_q    <= state_d;
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte storage; contents need no reset because occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Status outputs derive from the registered occupancy count.
  always_comb begin
    tx_en     = tx_en_q;
    tx_data   = tx_data_q;
    count     = count_q;
    empty     = (count_q == '0);
    full      = (count_q == DEPTH_C);
    overflow  = overflow_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: table vectors, directed corner sequences and randomized traffic
// for uart_tx_fifo, checked against a queue-based reference model.
module tb_uart_tx_fifo;

  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int HOLDOFF = 2;

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          tx_rdy;
  logic          tx_en;
  logic [7:0]    tx_data;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic [1:0]    dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .tx_rdy(tx_rdy),
    .tx_en(tx_en), .tx_data(tx_data), .count(count), .empty(empty),
    .full(full), .overflow(overflow), .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_en = -1;

  // ---------------- reference model ----------------
  // Stored bytes as a queue; the transmitter side is modelled by the cycle
  // number from which a ready transmitter may be re-armed after a pulse.
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  bit         m_idle;
  int         m_armed;
  int         m_cyc;
  bit         m_ovf;
  bit         m_txen;
  logic [7:0] m_txd;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    m_idle  = 1'b1;
    m_armed = 0;
    m_cyc   = 0;
    m_ovf   = 1'b0;
    m_txen  = 1'b0;
    m_txd   = 8'h00;
    last_en = -1;
  endtask

  task automatic model_edge(input bit we, input logic [7:0] wd, input bit rdy);
    bit pop;
    bit acc;
    m_cyc++;
    pop = m_idle && (model_q.size() > 0) && rdy;
    acc = we && ((model_q.size() < DEPTH) || pop);
    if (m_idle) begin
      if (pop) begin
        m_idle  = 1'b0;
        m_armed = m_cyc + HOLDOFF + 1;
      end
    end else if ((m_cyc >= m_armed) && rdy) begin
      m_idle = 1'b1;
    end
    m_txen = pop;
    if (pop) m_txd = model_q.pop_front();
    if (acc) begin
      model_q.push_back(wd);
      exp_q.push_back(wd);
    end else if (we) begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic check_all();
    logic [7:0] e;
    chk("count", int'(count), model_q.size());
    chk("empty", int'(empty), int'(model_q.size() == 0));
    chk("full", int'(full), int'(model_q.size() == DEPTH));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("tx_en", int'(tx_en), int'(m_txen));
    chk("tx_data", int'(tx_data), int'(m_txd));
    if (tx_en) begin
      chk("sb_nonempty", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_order", int'(tx_data), int'(e));
      end
      if (last_en >= 0) chk("spacing", int'((cyc - last_en) >= HOLDOFF + 2), 1);
      last_en = cyc;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_edge(input bit we, input logic [7:0] wd, input bit rdy);
    wr_en   = we;
    wr_data = wd;
    tx_rdy  = rdy;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step(input bit we, input logic [7:0] wd, input bit rdy);
    drive_edge(we, wd, rdy);
    model_edge(we, wd, rdy);
    check_all();
  endtask

  // Reset is raised between edges and outputs must clear without a clock edge.
  task automatic apply_reset();
    wr_en   = 1'b0;
    wr_data = 8'h00;
    tx_rdy  = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_tx_en", int'(tx_en), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    bit         we;
    logic [7:0] wd;
    bit         rdy;
    int         ecount;
    bit         etxen;
    logic [7:0] etxd;
    bit         eempty;
  } vec_t;

  vec_t tbl[7];

  int pulses;
  int seen_en;
  logic [7:0] last_byte;
  int wp;
  int rp;

  initial begin
    rst     = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    tx_rdy  = 1'b0;
    model_reset();

    // Single byte 42, then byte 7 written during the hold-off window.
    tbl[0] = '{1'b1, 8'd42, 1'b1, 1, 1'b0, 8'd0,  1'b0};
    tbl[1] = '{1'b0, 8'd0,  1'b1, 0, 1'b1, 8'd42, 1'b1};
    tbl[2] = '{1'b1, 8'd7,  1'b1, 1, 1'b0, 8'd42, 1'b0};
    tbl[3] = '{1'b0, 8'd0,  1'b1, 1, 1'b0, 8'd42, 1'b0};
    tbl[4] = '{1'b0, 8'd0,  1'b1, 1, 1'b0, 8'd42, 1'b0};
    tbl[5] = '{1'b0, 8'd0,  1'b1, 0, 1'b1, 8'd7,  1'b1};
    tbl[6] = '{1'b0, 8'd0,  1'b1, 0, 1'b0, 8'd7,  1'b1};

    #2;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      drive_edge(tbl[i].we, tbl[i].wd, tbl[i].rdy);
      model_edge(tbl[i].we, tbl[i].wd, tbl[i].rdy);
      chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].ecount);
      chk($sformatf("tbl%0d_tx_en", i), int'(tx_en), int'(tbl[i].etxen));
      chk($sformatf("tbl%0d_tx_data", i), int'(tx_data), int'(tbl[i].etxd));
      chk($sformatf("tbl%0d_empty", i), int'(empty), int'(tbl[i].eempty));
      check_all();
    end

    // Overflow: 17 writes with a stalled sink, then drain 0..15.
    apply_reset();
    for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0);
    chk("ovf_full", int'(full), 1);
    chk("ovf_count", int'(count), 16);
    chk("ovf_flag", int'(overflow), 1);
    pulses = 0;
    for (int i = 0; i < 120; i++) begin
      step(1'b0, 8'h00, 1'b1);
      if (tx_en) begin
        chk("ovf_drain_byte", int'(tx_data), pulses);
        pulses++;
      end
    end
    chk("ovf_pulses", pulses, 16);
    chk("ovf_drained", int'(count), 0);
    chk("ovf_sticky", int'(overflow), 1);

    // Full FIFO with a write on the pop edge.
    apply_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    step(1'b1, 8'hA5, 1'b1);
    chk("fullpop_tx_en", int'(tx_en), 1);
    chk("fullpop_count", int'(count), 16);
    chk("fullpop_overflow", int'(overflow), 0);
    last_byte = 8'h00;
    pulses = 1;
    for (int i = 0; i < 120; i++) begin
      step(1'b0, 8'h00, 1'b1);
      if (tx_en) begin
        last_byte = tx_data;
        pulses++;
      end
    end
    chk("fullpop_pulses", pulses, 17);
    chk("fullpop_last", int'(last_byte), 8'hA5);
    chk("fullpop_empty", int'(empty), 1);

    // Stalled sink with 4 bytes, then release.
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    seen_en = 0;
    for (int i = 0; i < 5000; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (tx_en) seen_en++;
    end
    chk("stall_no_tx_en", seen_en, 0);
    chk("stall_count", int'(count), 4);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 8'h00, 1'b1);
      if (tx_en) pulses++;
    end
    chk("stall_pulses", pulses, 4);

    // Reset mid-burst while the FSM sits in hold-off.
    apply_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_tx_en", int'(tx_en), 0);
    chk("midrst_count", int'(count), 0);
    chk("midrst_empty", int'(empty), 1);
    chk("midrst_overflow", int'(overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    seen_en = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 8'h00, 1'b1);
      if (tx_en) seen_en++;
    end
    chk("midrst_no_resume", seen_en, 0);

    // Randomized traffic at several write / ready densities.
    for (int r = 0; r < 3; r++) begin
      apply_reset();
      wp = (r == 0) ? 50 : (r == 1) ? 30 : 80;
      rp = (r == 0) ? 90 : (r == 1) ? 50 : 20;
      for (int i = 0; i < 1500; i++) begin
        step($urandom_range(99) < wp, 8'($urandom_range(255)), $urandom_range(99) < rp);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
